// File: rtl/maze_player_ctrl.sv
// Player movement for the VGA maze: once every S+1 frames, try a one-cell step
// in the DIP-selected direction, checking the target cell against the wall ROM.
module maze_player_ctrl #(
   parameter int MAZE_W  = 32,
   parameter int MAZE_H  = 24,
   parameter int START_X = 1,
   parameter int START_Y = 1,
   parameter int EXIT_X  = 30,
   parameter int EXIT_Y  = 22
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_frame_tick,
   input  logic [7:0] i_dip,
   output logic       o_rom_en,
   output logic [9:0] o_rom_addr,
   input  logic       i_rom_data,
   output logic [4:0] o_player_x,
   output logic [4:0] o_player_y,
   output logic       o_moved,
   output logic       o_exit_reached
);
   localparam logic [4:0] X_MAX = 5'(MAZE_W - 1);
   localparam logic [4:0] Y_MAX = 5'(MAZE_H - 1);
   localparam logic [4:0] SX    = 5'(START_X);
   localparam logic [4:0] SY    = 5'(START_Y);
   localparam logic [4:0] EX    = 5'(EXIT_X);
   localparam logic [4:0] EY    = 5'(EXIT_Y);

   typedef enum logic [1:0] {IDLE, READ, DECIDE} state_t;
   state_t state, state_n;

   logic [3:0] cnt;
   logic [3:0] dir;
   logic [3:0] spd;
   logic       attempt;
   logic       in_grid;
   logic [4:0] tx_n, ty_n;

   assign dir = i_dip[3:0];
   assign spd = i_dip[7:4];

   always_comb begin
      state_n = state;
      attempt = 1'b0;
      in_grid = 1'b0;
      tx_n    = o_player_x;
      ty_n    = o_player_y;
      if (state == IDLE && i_frame_tick && cnt >= spd) attempt = 1'b1;
      // Edge checks precede the +/-1 so coordinates never wrap.
      case (dir)
         4'b0001: begin in_grid = (o_player_y != 5'd0);  ty_n = o_player_y - 5'd1; end
         4'b0010: begin in_grid = (o_player_y != Y_MAX); ty_n = o_player_y + 5'd1; end
         4'b0100: begin in_grid = (o_player_x != 5'd0);  tx_n = o_player_x - 5'd1; end
         4'b1000: begin in_grid = (o_player_x != X_MAX); tx_n = o_player_x + 5'd1; end
         default: in_grid = 1'b0;
      endcase
      case (state)
         IDLE:    if (attempt && in_grid && !o_exit_reached) state_n = READ;
         READ:    state_n = DECIDE;
         DECIDE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // The latched target lives in o_rom_addr: {row, col}.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt            <= 4'd0;
         o_rom_en       <= 1'b0;
         o_rom_addr     <= 10'd0;
         o_player_x     <= SX;
         o_player_y     <= SY;
         o_moved        <= 1'b0;
         o_exit_reached <= 1'b0;
      end else begin
         o_moved <= 1'b0;
         if (o_player_x == EX && o_player_y == EY) o_exit_reached <= 1'b1;
         case (state)
            IDLE: if (i_frame_tick) begin
               if (cnt >= spd) cnt <= 4'd0;
               else            cnt <= cnt + 4'd1;
               if (state_n == READ) begin
                  o_rom_addr <= {ty_n, tx_n};
                  o_rom_en   <= 1'b1;
               end
            end
            READ: o_rom_en <= 1'b0;
            DECIDE: if (!i_rom_data) begin
               o_player_x <= o_rom_addr[4:0];
               o_player_y <= o_rom_addr[9:5];
               o_moved    <= 1'b1;
               if (o_rom_addr[4:0] == EX && o_rom_addr[9:5] == EY) o_exit_reached <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed bench for maze_player_ctrl: two instances (default exit, and exit
// next to the start) share a behavioural wall ROM.
module tb_maze_player_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0, tick_b = 1'b0;
   logic [7:0] dip = 8'h00;
   logic       wall [1024];

   logic       rom_en_a, rom_en_b, rom_data_a, rom_data_b;
   logic [9:0] rom_addr_a, rom_addr_b;
   logic [4:0] x_a, y_a, x_b, y_b;
   logic       moved_a, moved_b, exit_a, exit_b;

   int passed = 0, total = 0;
   int ens, mv;
   logic [9:0] addr;

   always #20 clk = ~clk;

   maze_player_ctrl dut_a (
      .clk(clk), .rst(rst), .i_frame_tick(tick), .i_dip(dip),
      .o_rom_en(rom_en_a), .o_rom_addr(rom_addr_a), .i_rom_data(rom_data_a),
      .o_player_x(x_a), .o_player_y(y_a), .o_moved(moved_a), .o_exit_reached(exit_a));

   maze_player_ctrl #(.EXIT_X(2), .EXIT_Y(1)) dut_b (
      .clk(clk), .rst(rst), .i_frame_tick(tick_b), .i_dip(dip),
      .o_rom_en(rom_en_b), .o_rom_addr(rom_addr_b), .i_rom_data(rom_data_b),
      .o_player_x(x_b), .o_player_y(y_b), .o_moved(moved_b), .o_exit_reached(exit_b));

   // Registered ROM: data follows one cycle after the enable.
   always_ff @(posedge clk) begin
      if (rom_en_a) rom_data_a <= wall[rom_addr_a];
      if (rom_en_b) rom_data_b <= wall[rom_addr_b];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   // One frame tick, then watch four cycles for ROM reads and move pulses.
   task automatic do_tick(input bit sel, output int n_en, output int n_mv, output logic [9:0] a);
      n_en = 0; n_mv = 0; a = '0;
      @(negedge clk); if (sel) tick_b = 1'b1; else tick = 1'b1;
      @(negedge clk); tick = 1'b0; tick_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (sel ? rom_en_b : rom_en_a) begin n_en++; a = sel ? rom_addr_b : rom_addr_a; end
         if (sel ? moved_b : moved_a) n_mv++;
         @(negedge clk);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) wall[i] = 1'b0;
      rom_data_a = 1'b0; rom_data_b = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_x", x_a, 5'd1);
      chk("rst_y", y_a, 5'd1);
      chk("rst_en", rom_en_a, 1'b0);
      chk("rst_addr", rom_addr_a, 10'd0);
      chk("rst_moved", moved_a, 1'b0);
      chk("rst_exit", exit_a, 1'b0);
      rst = 1'b0;

      // Up move with detailed cycle-by-cycle timing.
      dip = 8'h01;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      chk("up_en_T", rom_en_a, 1'b1);
      chk("up_addr_T", rom_addr_a, {5'd0, 5'd1});
      @(negedge clk);
      chk("up_en_T1", rom_en_a, 1'b0);
      chk("up_y_T1", y_a, 5'd1);
      @(negedge clk);
      chk("up_y_T2", y_a, 5'd0);
      chk("up_moved_T2", moved_a, 1'b1);
      @(negedge clk);
      chk("up_moved_off", moved_a, 1'b0);
      do_tick(0, ens, mv, addr);
      chk("up_edge_en", ens, 0);
      chk("up_edge_y", y_a, 5'd0);

      // Left with S=1: attempts on every second tick.
      do_reset(); dip = 8'h14;
      do_tick(0, ens, mv, addr); chk("l_t1_en", ens, 0);
      do_tick(0, ens, mv, addr); chk("l_t2_mv", mv, 1); chk("l_t2_x", x_a, 5'd0);
      do_tick(0, ens, mv, addr); chk("l_t3_en", ens, 0);
      do_tick(0, ens, mv, addr); chk("l_t4_en", ens, 0); chk("l_t4_x", x_a, 5'd0);
      dip = 8'h18;
      do_tick(0, ens, mv, addr); chk("r_t5_en", ens, 0);
      do_tick(0, ens, mv, addr); chk("r_t6_mv", mv, 1); chk("r_t6_x", x_a, 5'd1);

      // Wall to the right.
      do_reset(); dip = 8'h08; wall[{5'd1, 5'd2}] = 1'b1;
      do_tick(0, ens, mv, addr);
      chk("wall_en", ens, 1); chk("wall_addr", addr, {5'd1, 5'd2});
      chk("wall_mv", mv, 0); chk("wall_x", x_a, 5'd1);
      wall[{5'd1, 5'd2}] = 1'b0;

      // Invalid direction patterns.
      ens = 0;
      for (int k = 0; k < 5; k++) begin
         int e, m;
         dip = (k < 3) ? 8'h05 : 8'h00;
         do_tick(0, e, m, addr); ens += e;
      end
      chk("inv_en", ens, 0);
      chk("inv_pos", {x_a, y_a}, {5'd1, 5'd1});

      // Exit next to start on the second instance.
      chk("ex_pre", exit_b, 1'b0);
      dip = 8'h08;
      do_tick(1, ens, mv, addr);
      chk("ex_mv", mv, 1); chk("ex_x", x_b, 5'd2); chk("ex_flag", exit_b, 1'b1);
      dip = 8'h01; do_tick(1, ens, mv, addr); chk("ex_frz_en", ens, 0);
      dip = 8'h04; do_tick(1, ens, mv, addr); chk("ex_frz_en2", ens, 0);
      chk("ex_frz_pos", {x_b, y_b}, {5'd2, 5'd1});

      // Reset between T+1 and T+2 discards the pending move.
      do_reset(); dip = 8'h01;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
      rst = 1'b1; #1;
      chk("mr_y", y_a, 5'd1); chk("mr_en", rom_en_a, 1'b0); chk("mr_mv", moved_a, 1'b0);
      @(negedge clk); rst = 1'b0;
      mv = 0;
      repeat (3) begin @(negedge clk); if (moved_a) mv++; end
      chk("mr_nomove", mv, 0);
      do_tick(0, ens, mv, addr);
      chk("mr_fresh_en", ens, 1); chk("mr_fresh_y", y_a, 5'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
